v_matmul_engine: RTL and testbench

- 4x4 integer matrix-multiply sequencer that drives the vector register file's read and write ports.
- Reads matrix A and matrix B through the vector register file read ports:
  - A is four consecutive row vectors at rs1_addr.
  - B is four consecutive column vectors at rs2_addr.
- Computes C = A x B one row per cycle, then writes the four C row vectors back through the regfile write port in a single wen cycle.
- Sits between the vector instruction decode/issue logic and the vector register file.

---
 rtl/v_matmul_engine_pkg.sv | 25 ++
 rtl/v_matmul_engine_dot4.sv | 63 ++++++
 rtl/v_matmul_engine.sv | 124 ++++++++++++
 tb/tb_v_matmul_engine.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v_matmul_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : v_matmul_engine_pkg
// Purpose  : Shared types, constants and slice helper for the 4x4 matmul engine.
// Revision : 1.0 - initial release
// ============================================================================
package v_matmul_engine_pkg;

    localparam int MATMUL_DIM     = 4;
    localparam int MATMUL_LATENCY = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_WRITE   = 2'd3
    } mm_state_t;

    // Bit position of element k; element 0 sits in the LSBs of a vector.
    function automatic int elem_lsb(input int k, input int elem_width);
        return k * elem_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/v_matmul_engine_dot4.sv
`default_nettype none
// ============================================================================
// Module   : v_dot4
// Purpose  : Combinational signed 4-element dot product. With VMATMUL_SAT_EN
//            the sum is kept at full width and clamped to the signed range.
// Revision : 1.0 - initial release
// ============================================================================
module v_dot4
    import v_matmul_engine_pkg::*;
#(
    parameter int ELEM_WIDTH = 32
) (
    input  logic [MATMUL_DIM*ELEM_WIDTH-1:0] a_vec,
    input  logic [MATMUL_DIM*ELEM_WIDTH-1:0] b_vec,
    output logic [ELEM_WIDTH-1:0]            dot
);

`ifdef VMATMUL_SAT_EN
    localparam int ACC_W = 2*ELEM_WIDTH + 2;
`else
    // Wrap-around only needs the low bits, so accumulate at element width.
    localparam int ACC_W = ELEM_WIDTH;
`endif

    logic signed [ACC_W-1:0] w_prod [MATMUL_DIM];
    logic signed [ACC_W-1:0] w_acc;

    for (genvar k = 0; k < MATMUL_DIM; k++) begin : g_prod
        logic signed [ELEM_WIDTH-1:0] w_a;
        logic signed [ELEM_WIDTH-1:0] w_b;
        assign w_a       = a_vec[elem_lsb(k, ELEM_WIDTH) +: ELEM_WIDTH];
        assign w_b       = b_vec[elem_lsb(k, ELEM_WIDTH) +: ELEM_WIDTH];
        assign w_prod[k] = ACC_W'(w_a) * ACC_W'(w_b);
    end

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < MATMUL_DIM; k++) begin
            w_acc = w_acc + w_prod[k];
        end
    end

`ifdef VMATMUL_SAT_EN
    localparam logic signed [ACC_W-1:0] c_SAT_MAX =
        {{(ACC_W-ELEM_WIDTH+1){1'b0}}, {(ELEM_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_SAT_MIN =
        {{(ACC_W-ELEM_WIDTH+1){1'b1}}, {(ELEM_WIDTH-1){1'b0}}};

    always_comb begin
        if (w_acc > c_SAT_MAX) begin
            dot = c_SAT_MAX[ELEM_WIDTH-1:0];
        end else if (w_acc < c_SAT_MIN) begin
            dot = c_SAT_MIN[ELEM_WIDTH-1:0];
        end else begin
            dot = w_acc[ELEM_WIDTH-1:0];
        end
    end
`else
    assign dot = w_acc;
`endif

endmodule
`default_nettype wire

// File: rtl/v_matmul_engine.sv
`default_nettype none
// ============================================================================
// Module   : v_matmul_engine
// Purpose  : 4x4 integer matmul sequencer driving the vector regfile ports.
//            Optional macro VMATMUL_SAT_EN selects saturating results.
// Revision : 1.0 - initial release
// ============================================================================
module v_matmul_engine
    import v_matmul_engine_pkg::*;
#(
    parameter  int VLEN       = 128,
    parameter  int ELEM_WIDTH = 32,
    parameter  int VREG_DEPTH = 32,
    localparam int REG_WIDTH  = $clog2(VREG_DEPTH)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic [REG_WIDTH-1:0]             src_a,
    input  logic [REG_WIDTH-1:0]             src_b,
    input  logic [REG_WIDTH-1:0]             dst,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic [REG_WIDTH-1:0]             rs1_addr,
    output logic [REG_WIDTH-1:0]             rs2_addr,
    input  logic [MATMUL_DIM-1:0][VLEN-1:0]  rs1_data,
    input  logic [MATMUL_DIM-1:0][VLEN-1:0]  rs2_data,
    output logic                             wen,
    output logic [REG_WIDTH-1:0]             rd_addr,
    output logic [MATMUL_DIM-1:0][VLEN-1:0]  rd_data
);

    localparam logic [REG_WIDTH-1:0] c_MAX_BASE = REG_WIDTH'(VREG_DEPTH - MATMUL_DIM);

    if ((VLEN % ELEM_WIDTH != 0) || (VLEN / ELEM_WIDTH != MATMUL_DIM)) begin : g_bad_geometry
        $error("v_matmul_engine: VLEN/ELEM_WIDTH must equal %0d", MATMUL_DIM);
    end

    mm_state_t                              r_state;
    logic [1:0]                             r_row;
    logic [REG_WIDTH-1:0]                   r_dst;
    logic [MATMUL_DIM-1:0][VLEN-1:0]        r_a;
    logic [MATMUL_DIM-1:0][VLEN-1:0]        r_b;
    logic [MATMUL_DIM-1:0][VLEN-1:0]        r_res;
    logic [MATMUL_DIM-1:0][ELEM_WIDTH-1:0]  w_row;
    logic                                   w_req_ok;

    // All four consecutive registers of each operand must exist.
    assign w_req_ok = (src_a <= c_MAX_BASE) && (src_b <= c_MAX_BASE) && (dst <= c_MAX_BASE);

    for (genvar j = 0; j < MATMUL_DIM; j++) begin : g_col
        v_dot4 #(
            .ELEM_WIDTH (ELEM_WIDTH)
        ) u_dot (
            .a_vec (r_a[r_row]),
            .b_vec (r_b[j]),
            .dot   (w_row[j])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_row    <= '0;
            r_dst    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wen      <= 1'b0;
            rs1_addr <= '0;
            rs2_addr <= '0;
            rd_addr  <= '0;
            rd_data  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            wen  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_req_ok) begin
                            rs1_addr <= src_a;
                            rs2_addr <= src_b;
                            r_dst    <= dst;
                            busy     <= 1'b1;
                            r_state  <= ST_LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    r_a     <= rs1_data;
                    r_b     <= rs2_data;
                    r_row   <= '0;
                    r_state <= ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    r_res[r_row] <= w_row;
                    r_row        <= r_row + 2'd1;
                    // Outputs are registered, so the write is staged on the last row.
                    if (r_row == 2'd3) begin
                        rd_data <= {w_row, r_res[2], r_res[1], r_res[0]};
                        rd_addr <= r_dst;
                        wen     <= 1'b1;
                        done    <= 1'b1;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_v_matmul_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_v_matmul_engine
// Purpose  : Scoreboard bench for v_matmul_engine with a behavioural regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_v_matmul_engine;
    import v_matmul_engine_pkg::*;

    localparam int VLEN  = 128;
    localparam int EW    = 32;
    localparam int DEPTH = 32;
    localparam int RW    = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic [RW-1:0] src_a = '0, src_b = '0, dst = '0;
    logic busy, done, err, wen;
    logic [RW-1:0] rs1_addr, rs2_addr, rd_addr;
    logic [3:0][VLEN-1:0] rs1_data, rs2_data, rd_data;

    always #5 clk = ~clk;

    v_matmul_engine #(
        .VLEN       (VLEN),
        .ELEM_WIDTH (EW),
        .VREG_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .src_a    (src_a),
        .src_b    (src_b),
        .dst      (dst),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wen      (wen),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    // Behavioural register file: combinational reads, DUT write port has priority.
    logic [VLEN-1:0] regs [DEPTH];
    logic            tb_we = 1'b0;
    logic [RW-1:0]   tb_waddr = '0;
    logic [VLEN-1:0] tb_wdata = '0;

    always @(posedge clk) begin
        if (wen) begin
            for (int i = 0; i < 4; i++) regs[RW'(rd_addr + i)] <= rd_data[i];
        end else if (tb_we) begin
            regs[tb_waddr] <= tb_wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rs1_data[i] = regs[RW'(rs1_addr + i)];
            rs2_data[i] = regs[RW'(rs2_addr + i)];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit                   is_err;
        int                   cyc;
        logic [RW-1:0]        addr;
        logic [3:0][VLEN-1:0] data;
    } ev_t;

    ev_t                  q[$];
    int                   checks = 0;
    int                   errors = 0;
    int                   busy_lo = 1;
    int                   busy_hi = 0;
    bit                   mon_en = 1'b0;
    logic [VLEN-1:0]      exp_regs [DEPTH];
    logic [3:0][VLEN-1:0] last_c = '0;
    logic [3:0][VLEN-1:0] pend_c = '0;

    function automatic void check(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    function automatic logic [VLEN-1:0] mkvec(input logic [31:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    // C[i][j] = sum_k A[i][k] * B[j][k] using exact integer arithmetic.
    function automatic logic [3:0][VLEN-1:0] model_c(input int a, input int b);
        logic [3:0][VLEN-1:0] c;
        logic signed [127:0]  acc;
        longint               x, y;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) begin
                    x   = longint'($signed(exp_regs[a+i][32*k +: 32]));
                    y   = longint'($signed(exp_regs[b+j][32*k +: 32]));
                    acc = acc + 128'(x * y);
                end
`ifdef VMATMUL_SAT_EN
                if (acc > 128'sd2147483647)       c[i][32*j +: 32] = 32'h7fffffff;
                else if (acc < -128'sd2147483648) c[i][32*j +: 32] = 32'h80000000;
                else                              c[i][32*j +: 32] = acc[31:0];
`else
                c[i][32*j +: 32] = acc[31:0];
`endif
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] rnd_elem();
        case ($urandom_range(0, 2))
            0:       return $urandom();
            1:       return 32'($urandom_range(0, 16)) - 32'd8;
            default: return ($urandom_range(0, 1) != 0) ? 32'h7fffffff : 32'h80000000;
        endcase
    endfunction

    // Monitor: per-cycle busy check plus scoreboard pop on any output event.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("busy", 512'(busy), 512'(cyc >= busy_lo && cyc <= busy_hi));
                if (wen || done || err) begin
                    if (q.size() == 0) begin
                        check("unexpected_event", 512'({wen, done, err}), 512'(0));
                    end else begin
                        e = q.pop_front();
                        check("event_cycle", 512'(cyc), 512'(e.cyc));
                        check("err",  512'(err),  512'(e.is_err));
                        check("wen",  512'(wen),  512'(!e.is_err));
                        check("done", 512'(done), 512'(!e.is_err));
                        if (!e.is_err) begin
                            check("rd_addr", 512'(rd_addr), 512'(e.addr));
                            check("rd_data", rd_data, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic load_reg(input int addr, input logic [VLEN-1:0] data);
        tb_we          = 1'b1;
        tb_waddr       = RW'(addr);
        tb_wdata       = data;
        exp_regs[addr] = data;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic issue(input int a, input int b, input int d, output bit ok);
        int t;
        start = 1'b1;
        src_a = RW'(a);
        src_b = RW'(b);
        dst   = RW'(d);
        t     = cyc;
        ok    = (a <= DEPTH-4) && (b <= DEPTH-4) && (d <= DEPTH-4);
        if (ok) begin
            pend_c  = model_c(a, b);
            q.push_back('{is_err: 1'b0, cyc: t + MATMUL_LATENCY, addr: RW'(d), data: pend_c});
            busy_lo = t + 1;
            busy_hi = t + MATMUL_LATENCY;
        end else begin
            q.push_back('{is_err: 1'b1, cyc: t + 1, addr: '0, data: '0});
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_op(input bit ok, input int d, input int wait_cycles);
        int mism;
        repeat (wait_cycles) @(posedge clk);
        #1;
        check("drain", 512'(q.size()), 512'(0));
        q.delete();
        if (ok) begin
            for (int i = 0; i < 4; i++) exp_regs[d+i] = pend_c[i];
            last_c = pend_c;
        end
        mism = 0;
        for (int r = 0; r < DEPTH; r++) if (regs[r] !== exp_regs[r]) mism++;
        check("regfile", 512'(mism), 512'(0));
        check("rd_data_hold", rd_data, last_c);
    endtask

    task automatic run(input int a, input int b, input int d);
        bit ok;
        issue(a, b, d, ok);
        finish_op(ok, d, MATMUL_LATENCY);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int a, b, d;
        @(posedge clk); #1;
        for (int r = 0; r < DEPTH; r++) load_reg(r, {$urandom(), $urandom(), $urandom(), $urandom()});
        reset_n = 1'b1;
        check("reset_ctrl", 512'({busy, done, err, wen, rs1_addr, rs2_addr, rd_addr}), 512'(0));
        check("reset_rd_data", rd_data, '0);
        mon_en = 1'b1;

        // Identity A times column-major B yields B transposed.
        for (int i = 0; i < 4; i++)
            load_reg(i, mkvec(32'(i == 0), 32'(i == 1), 32'(i == 2), 32'(i == 3)));
        for (int j = 0; j < 4; j++)
            load_reg(4 + j, mkvec(32'(4*j+1), 32'(4*j+2), 32'(4*j+3), 32'(4*j+4)));
        run(0, 4, 8);
        check("identity_row1", regs[9], mkvec(2, 6, 10, 14));

        for (int i = 0; i < 4; i++) load_reg(i, mkvec(2, 2, 2, 2));
        for (int i = 4; i < 8; i++) load_reg(i, mkvec(3, 3, 3, 3));
        run(0, 4, 8);
        check("general_row2", regs[10], mkvec(24, 24, 24, 24));

        for (int i = 0; i < 8; i++) load_reg(i, {4{32'h40000000}});
        run(0, 4, 12);
`ifdef VMATMUL_SAT_EN
        check("overflow_pos", regs[12], {4{32'h7fffffff}});
`else
        check("overflow_pos", regs[12], '0);
`endif
        for (int i = 0; i < 4; i++) load_reg(i, {4{32'h80000000}});
        for (int i = 4; i < 8; i++) load_reg(i, mkvec(1, 1, 1, 1));
        run(0, 4, 12);
`ifdef VMATMUL_SAT_EN
        check("overflow_neg", regs[15], {4{32'h80000000}});
`else
        check("overflow_neg", regs[15], '0);
`endif

        run(0, 4, 29);
        run(30, 0, 8);
        run(0, 31, 8);

        // A second start while busy must be dropped.
        for (int i = 0; i < 8; i++) load_reg(i, mkvec(rnd_elem(), rnd_elem(), rnd_elem(), rnd_elem()));
        issue(0, 4, 8, ok);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; src_a = 5'd4; src_b = 5'd0; dst = 5'd12;
        @(posedge clk); #1;
        start = 1'b0;
        finish_op(ok, 8, 3 + 2*MATMUL_LATENCY);

        // Reset in the middle of COMPUTE aborts without a write.
        issue(4, 0, 16, ok);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        busy_hi = cyc;
        q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("midop_reset_ctrl", 512'({busy, done, err, wen, rs1_addr, rs2_addr, rd_addr}), 512'(0));
        last_c = '0;
        finish_op(1'b0, 16, MATMUL_LATENCY);
        run(4, 0, 16);

        for (int n = 0; n < 25; n++) begin
            a = ($urandom_range(0, 9) == 0) ? $urandom_range(29, 31) : $urandom_range(0, 28);
            b = ($urandom_range(0, 9) == 0) ? $urandom_range(29, 31) : $urandom_range(0, 28);
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(29, 31) : $urandom_range(0, 28);
            if (a <= DEPTH-4)
                for (int i = 0; i < 4; i++) load_reg(a + i, mkvec(rnd_elem(), rnd_elem(), rnd_elem(), rnd_elem()));
            if (b <= DEPTH-4)
                for (int i = 0; i < 4; i++) load_reg(b + i, mkvec(rnd_elem(), rnd_elem(), rnd_elem(), rnd_elem()));
            run(a, b, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
